// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the AGU memory access unit.
// Byte-lane, alignment and load-extension rules live here.
package mem_pkg;

  localparam int XLEN   = 32;
  localparam int PREG_W = 6;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } mau_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic              is_store;
    mem_size_e         size;
    logic              ld_unsigned;
    logic [XLEN-1:0]   st_data;
    logic [PREG_W-1:0] dst_reg;
  } lsu_req_t;

  function automatic logic is_misaligned(
    mem_size_e  sz,
    logic [1:0] off
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      sz == SZ_B: r = 1'b0;
      sz == SZ_H: r = off[0];
      default:    r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] be_of(
    mem_size_e  sz,
    logic [1:0] off
  );
    logic [3:0] r;
    r = 4'hF;
    unique case (1'b1)
      sz == SZ_B: r = 4'b0001 << off;
      sz == SZ_H: r = 4'b0011 << off;
      default:    r = 4'hF;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(
    logic [XLEN-1:0] rdata,
    logic [1:0]      off,
    mem_size_e       sz,
    logic            uns
  );
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] r;
    sh = rdata >> {off, 3'b000};
    r  = sh;
    unique case (1'b1)
      sz == SZ_B:
        r = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      sz == SZ_H:
        r = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      default:
        r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// AGU request, data-memory bus and writeback signals of the
// memory access unit, bundled with directional modports.
interface mem_access_unit_if;
  import mem_pkg::*;

  logic              addr_valid;
  logic              addr_ready;
  logic [XLEN-1:0]   mem_addr_in;
  logic              is_store;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [XLEN-1:0]   st_data;
  logic [PREG_W-1:0] dst_reg;
  logic              flush;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [3:0]        mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              wb_valid;
  logic [PREG_W-1:0] wb_dst_index;
  logic [XLEN-1:0]   wb_dst_val;
  logic              st_done;
  logic              misalign;
  logic [PREG_W-1:0] misalign_dst;

  modport slave (
    input  addr_valid, mem_addr_in, is_store, size,
    input  ld_unsigned, st_data, dst_reg, flush,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output addr_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output wb_valid, wb_dst_index, wb_dst_val,
    output st_done, misalign, misalign_dst
  );

  modport master (
    output addr_valid, mem_addr_in, is_store, size,
    output ld_unsigned, st_data, dst_reg, flush,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  addr_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  wb_valid, wb_dst_index, wb_dst_val,
    input  st_done, misalign, misalign_dst
  );

endinterface

// File: rtl/mem_access_unit_fifo.sv
// In-order request queue for the memory access unit.
// Full is derived from the registered count only.
module lsu_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  lsu_req_t din_i,
  input  logic     pop_i,
  input  logic     flush_i,
  output lsu_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  lsu_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/mem_access_unit.sv
// AGU-side memory responder: queues requests, runs one bus
// access at a time and returns extended load results.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  lsu_req_t   req_in, head;
  logic       push, pop, full, empty;
  logic       in_req;

  mau_state_e        state_q, state_d;
  logic [PREG_W-1:0] ld_dst_q, ld_dst_d;
  logic [1:0]        ld_off_q, ld_off_d;
  mem_size_e         ld_size_q, ld_size_d;
  logic              ld_uns_q, ld_uns_d;

  logic              wb_valid_q, wb_valid_d;
  logic [PREG_W-1:0] wb_dst_q, wb_dst_d;
  logic [XLEN-1:0]   wb_val_q, wb_val_d;
  logic              st_done_q, st_done_d;
  logic              mis_q, mis_d;
  logic [PREG_W-1:0] mis_dst_q, mis_dst_d;

  assign req_in = '{
    addr:        bus.mem_addr_in,
    is_store:    bus.is_store,
    size:        mem_size_e'(bus.size),
    ld_unsigned: bus.ld_unsigned,
    st_data:     bus.st_data,
    dst_reg:     bus.dst_reg
  };

  assign push           = bus.addr_valid & ~full & ~bus.flush;
  assign bus.addr_ready = ~full;

  lsu_req_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (req_in),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    ld_dst_d   = ld_dst_q;
    ld_off_d   = ld_off_q;
    ld_size_d  = ld_size_q;
    ld_uns_d   = ld_uns_q;
    wb_valid_d = 1'b0;
    wb_dst_d   = wb_dst_q;
    wb_val_d   = wb_val_q;
    st_done_d  = 1'b0;
    mis_d      = 1'b0;
    mis_dst_d  = mis_dst_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.flush && !empty) begin
          if (is_misaligned(head.size, head.addr[1:0])) begin
            pop       = 1'b1;
            mis_d     = 1'b1;
            mis_dst_d = head.dst_reg;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // A load granted alongside a flush still owes us an rvalid
        if (bus.flush) begin
          state_d = (bus.mem_gnt && !head.is_store) ? DRAIN : IDLE;
        end else if (bus.mem_gnt) begin
          pop = 1'b1;
          if (head.is_store) begin
            st_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            ld_dst_d  = head.dst_reg;
            ld_off_d  = head.addr[1:0];
            ld_size_d = head.size;
            ld_uns_d  = head.ld_unsigned;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
          if (!bus.flush) begin
            wb_valid_d = 1'b1;
            wb_dst_d   = ld_dst_q;
            wb_val_d   = load_extend(bus.mem_rdata, ld_off_q,
                                     ld_size_q, ld_uns_q);
          end
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ld_dst_q   <= '0;
      ld_off_q   <= '0;
      ld_size_q  <= SZ_B;
      ld_uns_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_dst_q   <= '0;
      wb_val_q   <= '0;
      st_done_q  <= 1'b0;
      mis_q      <= 1'b0;
      mis_dst_q  <= '0;
    end else begin
      state_q    <= state_d;
      ld_dst_q   <= ld_dst_d;
      ld_off_q   <= ld_off_d;
      ld_size_q  <= ld_size_d;
      ld_uns_q   <= ld_uns_d;
      wb_valid_q <= wb_valid_d;
      wb_dst_q   <= wb_dst_d;
      wb_val_q   <= wb_val_d;
      st_done_q  <= st_done_d;
      mis_q      <= mis_d;
      mis_dst_q  <= mis_dst_d;
    end
  end

  assign in_req        = (state_q == REQ);
  assign bus.mem_req   = in_req;
  assign bus.mem_we    = in_req & head.is_store;
  assign bus.mem_addr  = in_req ? {head.addr[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_be    = in_req ? be_of(head.size, head.addr[1:0]) : '0;
  assign bus.mem_wdata = in_req ? head.st_data << {head.addr[1:0], 3'b000}
                                : '0;

  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_dst_index = wb_dst_q;
  assign bus.wb_dst_val   = wb_val_q;
  assign bus.st_done      = st_done_q;
  assign bus.misalign     = mis_q;
  assign bus.misalign_dst = mis_dst_q;

  a_no_overrun: assert property (@(posedge clk) disable iff (!rst)
    !(bus.addr_valid && !bus.addr_ready));

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases, then
// random traffic against a byte-level memory model.
module tb_mem_access_unit;

  typedef struct {
    int       kind;
    bit [5:0] dst;
    bit [31:0] val;
  } exp_t;

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [3:0]  be;
    bit [31:0] wd;
  } bexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  mem_access_unit_if bus();

  mem_access_unit #(.QUEUE_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t  exp_q[$];
  bexp_t bus_q[$];
  bit [31:0] model_mem [bit [31:0]];
  bit [31:0] bus_mem   [bit [31:0]];

  bit        hold_gnt = 1'b0;
  int        fix_lat  = 0;
  int        rv_cnt   = 0;
  bit [31:0] rv_data;
  int        gnt_count = 0;
  int        wb_pulses = 0, st_pulses = 0, mis_pulses = 0;
  bit [31:0] last_addr, last_wd, last_wb_val;
  bit [3:0]  last_be;
  bit [5:0]  last_wb_dst, last_mis_dst;

  function automatic bit [31:0] pat(bit [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic bit [31:0] mrd(bit [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : pat(a);
  endfunction

  function automatic bit [31:0] brd(bit [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : pat(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setmem(input bit [31:0] a, input bit [31:0] v);
    model_mem[a] = v;
    bus_mem[a]   = v;
  endtask

  task automatic got(input int k, input logic [5:0] d,
                     input logic [31:0] v);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind %0d dst %0d val %h", k, d, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k != 1 && d !== e.dst) ||
          (k == 0 && v !== e.val)) begin
        n_fail++;
        $display("FAIL event: got kind %0d dst %0d val %h expected kind %0d dst %0d val %h",
                 k, d, v, e.kind, e.dst, e.val);
      end
    end
  endtask

  // Output monitor: every result pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst) begin
      if (bus.wb_valid) begin
        wb_pulses++;
        last_wb_val = bus.wb_dst_val;
        last_wb_dst = bus.wb_dst_index;
        got(0, bus.wb_dst_index, bus.wb_dst_val);
      end
      if (bus.st_done) begin
        st_pulses++;
        got(1, 6'd0, 32'd0);
      end
      if (bus.misalign) begin
        mis_pulses++;
        last_mis_dst = bus.misalign_dst;
        got(2, bus.misalign_dst, 32'd0);
      end
    end
  end

  // Memory responder with random grant and read latency
  always @(negedge clk) begin
    bexp_t     b;
    bit [31:0] mask, w;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    if (rv_cnt > 0) begin
      rv_cnt--;
      if (rv_cnt == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rv_data;
      end
    end
    if (rst && bus.mem_req && !hold_gnt && $urandom_range(0, 3) != 0) begin
      bus.mem_gnt = 1'b1;
      gnt_count++;
      last_addr = bus.mem_addr;
      last_be   = bus.mem_be;
      last_wd   = bus.mem_wdata;
      mask = '0;
      for (int i = 0; i < 4; i++)
        if (bus.mem_be[i]) mask[8*i+:8] = 8'hFF;
      n_tests++;
      if (bus_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_req: addr %h we %b", bus.mem_addr, bus.mem_we);
      end else begin
        b = bus_q.pop_front();
        if (bus.mem_we !== b.we || bus.mem_addr !== b.addr ||
            bus.mem_be !== b.be ||
            (b.we && (bus.mem_wdata & mask) !== b.wd)) begin
          n_fail++;
          $display("FAIL bus: got we %b addr %h be %b wd %h expected we %b addr %h be %b wd %h",
                   bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                   b.we, b.addr, b.be, b.wd);
        end
      end
      w = brd(bus.mem_addr);
      if (bus.mem_we) begin
        for (int i = 0; i < 4; i++)
          if (bus.mem_be[i]) w[8*i+:8] = bus.mem_wdata[8*i+:8];
        bus_mem[bus.mem_addr] = w;
      end else begin
        rv_data = w;
        rv_cnt  = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
      end
    end
  end

  task automatic issue(input bit st, input bit [1:0] sz,
                       input bit [31:0] a, input bit uns,
                       input bit [31:0] d, input bit [5:0] dst,
                       input bit pb, input bit pr);
    int        off, nb, w;
    bit [31:0] wa, word, v, wd;
    bit [3:0]  be;
    w = 0;
    while (!bus.addr_ready && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    off = int'(a[1:0]);
    nb  = 1 << sz;
    wa  = {a[31:2], 2'b00};
    if (off % nb != 0) begin
      if (pr) exp_q.push_back('{2, dst, 32'd0});
    end else begin
      be = '0;
      wd = '0;
      for (int i = 0; i < nb; i++) begin
        be[off+i] = 1'b1;
        wd[8*(off+i)+:8] = d[8*i+:8];
      end
      if (pb) bus_q.push_back('{st, wa, be, wd});
      word = mrd(wa);
      if (st) begin
        for (int i = 0; i < nb; i++) word[8*(off+i)+:8] = d[8*i+:8];
        model_mem[wa] = word;
        if (pr) exp_q.push_back('{1, dst, 32'd0});
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i+:8] = word[8*(off+i)+:8];
        if (!uns && v[8*nb-1])
          for (int j = 8*nb; j < 32; j++) v[j] = 1'b1;
        if (pr) exp_q.push_back('{0, dst, v});
      end
    end
    bus.addr_valid  = 1'b1;
    bus.is_store    = st;
    bus.size        = sz;
    bus.mem_addr_in = a;
    bus.ld_unsigned = uns;
    bus.st_data     = d;
    bus.dst_reg     = dst;
    @(posedge clk); #1;
    bus.addr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || bus_q.size() != 0) && w < 1000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 1000) chk("drain_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, p0, w;
    bus.addr_valid = 0; bus.mem_addr_in = 0; bus.is_store = 0;
    bus.size = 0; bus.ld_unsigned = 0; bus.st_data = 0;
    bus.dst_reg = 0; bus.flush = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_st_done", bus.st_done, 0);
    chk("rst_misalign", bus.misalign, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    rst = 1'b1;
    chk("rst_ready", bus.addr_ready, 1);
    @(posedge clk); #1;

    // 1: lw with two-cycle read latency
    fix_lat = 2;
    setmem(32'h100, 32'hDEADBEEF);
    p0 = wb_pulses;
    issue(0, 2'd2, 32'h100, 0, 0, 6'd17, 1, 1);
    wait_idle();
    chk("lw_val", last_wb_val, 32'hDEADBEEF);
    chk("lw_dst", last_wb_dst, 17);
    chk("lw_pulses", wb_pulses - p0, 1);

    // 2: lb / lbu at the top byte lane
    setmem(32'h100, 32'h80112233);
    issue(0, 2'd0, 32'h103, 0, 0, 6'd3, 1, 1);
    wait_idle();
    chk("lb_val", last_wb_val, 32'hFFFFFF80);
    issue(0, 2'd0, 32'h103, 1, 0, 6'd4, 1, 1);
    wait_idle();
    chk("lbu_val", last_wb_val, 32'h00000080);

    // 3: sh to upper half
    p0 = st_pulses;
    issue(1, 2'd1, 32'h102, 0, 32'h0000ABCD, 6'd0, 1, 1);
    wait_idle();
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wd, 32'hABCD0000);
    chk("sh_addr", last_addr, 32'h100);
    chk("sh_done", st_pulses - p0, 1);

    // 4: misaligned lw rejected, next request served
    g0 = gnt_count;
    p0 = mis_pulses;
    issue(0, 2'd2, 32'h101, 0, 0, 6'd42, 1, 1);
    issue(0, 2'd2, 32'h104, 0, 0, 6'd43, 1, 1);
    wait_idle();
    chk("mis_pulse", mis_pulses - p0, 1);
    chk("mis_dst", last_mis_dst, 42);
    chk("mis_grants", gnt_count - g0, 1);

    // 5: fill the queue with grant held off
    fix_lat = 0;
    hold_gnt = 1'b1;
    for (int i = 0; i < 4; i++)
      issue(i[0], 2'd2, 32'h200 + 32'(4*i), 0, $urandom, 6'(10+i), 1, 1);
    chk("full_ready", bus.addr_ready, 0);
    hold_gnt = 1'b0;
    issue(0, 2'd2, 32'h204, 0, 0, 6'd20, 1, 1);
    wait_idle();

    // 6: flush while a load waits for data
    fix_lat = 6;
    g0 = gnt_count;
    p0 = wb_pulses;
    issue(0, 2'd2, 32'h300, 0, 0, 6'd5, 1, 0);
    w = 0;
    while (gnt_count == g0 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("flush_wait_gnt", gnt_count - g0, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_wait_ready", bus.addr_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("flush_wait_nowb", wb_pulses - p0, 0);
    fix_lat = 0;

    // flush while requesting drops mem_req
    hold_gnt = 1'b1;
    issue(0, 2'd2, 32'h304, 0, 0, 6'd6, 0, 0);
    w = 0;
    while (!bus.mem_req && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("flush_req_seen", bus.mem_req, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_req_drop", bus.mem_req, 0);
    hold_gnt = 1'b0;
    g0 = gnt_count;
    repeat (5) @(posedge clk);
    #1;
    chk("flush_req_nognt", gnt_count - g0, 0);
    issue(0, 2'd1, 32'h102, 0, 0, 6'd7, 1, 1);
    wait_idle();

    // random traffic
    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            32'h400 + 32'($urandom_range(0, 7) * 4) +
            32'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom,
            6'($urandom_range(0, 63)), 1, 1);
    end
    wait_idle();
    chk("end_exp_q", exp_q.size(), 0);
    chk("end_bus_q", bus_q.size(), 0);
    chk("end_idle_req", bus.mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
